// File: rtl/arb_mux_pkg.sv
// Shared defaults and mode encodings for the arb_mux registered N-channel multiplexer.
// The round-robin arbiter is built only when ARB_MUX_RR_EN is defined.
package arb_mux_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_SEL_W    = 2;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Next channel index after idx, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter for arb_mux: scans requests starting at the pointer and owns
// the pointer register. Instantiated only when ARB_MUX_RR_EN is defined.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req_i,
    input  logic                advance_i,
    output logic [CHANNELS-1:0] gnt_o,
    output logic [SEL_W-1:0]    gnt_idx_o
);

    logic [SEL_W-1:0]      ptr_q, ptr_d;
    logic [2*CHANNELS-1:0] req_dbl;
    logic [CHANNELS-1:0]   req_rot;
    logic                  found;
    logic [SEL_W-1:0]      offset;
    logic [SEL_W:0]        idx_sum;

    // Rotating a doubled copy puts the pointer's channel at bit 0 of req_rot.
    assign req_dbl = {req_i, req_i};
    assign req_rot = CHANNELS'(req_dbl >> ptr_q);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        found     = 1'b0;
        offset    = '0;
        idx_sum   = '0;
        gnt_idx_o = '0;
        gnt_o     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && req_rot[k]) begin
                found  = 1'b1;
                offset = SEL_W'(k);
            end
        end
        idx_sum = {1'b0, ptr_q} + {1'b0, offset};
        if (idx_sum >= (SEL_W+1)'(CHANNELS)) begin
            idx_sum = idx_sum - (SEL_W+1)'(CHANNELS);
        end
        gnt_idx_o = idx_sum[SEL_W-1:0];
        if (found) begin
            gnt_o = CHANNELS'(1) << gnt_idx_o;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = SEL_W'(wrap_inc(int'(gnt_idx_o), CHANNELS));
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// Registered N-channel valid/ready multiplexer with explicit select or round-robin grant.
// Define ARB_MUX_RR_EN to build the round-robin arbiter; otherwise select mode is always used.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      rr_mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;

    logic                can_accept;
    logic                xfer;
    logic [CHANNELS-1:0] sel_gnt;
    logic [CHANNELS-1:0] gnt_vec;
    logic [SEL_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]    gnt_data;

    // An out-of-range sel matches no channel, so it grants nothing.
    always_comb begin
        sel_gnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_gnt[i] = in_valid[i] && (sel == SEL_W'(i));
        end
    end

`ifdef ARB_MUX_RR_EN
    mode_e               mode;
    logic                rr_adv;
    logic [CHANNELS-1:0] rr_gnt;
    logic [SEL_W-1:0]    rr_idx;

    assign mode   = mode_e'(rr_mode);
    assign rr_adv = xfer && (mode == MODE_RR);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req_i     (in_valid),
        .advance_i (rr_adv),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx)
    );

    assign gnt_vec = (mode == MODE_RR) ? rr_gnt : sel_gnt;
    assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
`else
    logic unused_rr_mode;

    assign unused_rr_mode = rr_mode;
    assign gnt_vec        = sel_gnt;
    assign gnt_idx        = sel;
`endif

    assign can_accept = !out_valid_q || out_ready;
    assign in_ready   = can_accept ? gnt_vec : '0;
    assign xfer       = |(in_valid & in_ready);

    // Grant vector is one-hot, so an OR of the gated channels is the selected word.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_vec[i]) begin
                gnt_data = gnt_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
